// File: rtl/bsg_adder_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder.
package bsg_adder_pkg;

  // Operation select, encoded directly from sub_i.
  typedef enum logic {
    eAdd = 1'b0,
    eSub = 1'b1
  } bsg_adder_op_e;

  // Occupancy of one pipeline slice.
  typedef enum logic {
    eEmpty = 1'b0,
    eFull  = 1'b1
  } bsg_adder_stage_e;

  // Bits added per slice for a given overall width and slice count.
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/bsg_adder_pipe_stage.sv
// One slice of the pipelined adder: occupancy bit, slice ripple add,
// carry register and pass-through of the operands and partial sum.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   eEmpty | no operand pair held in this slice
//   eFull  | slice holds a pair whose low slices are summed
module bsg_adder_pipe_stage
  import bsg_adder_pkg::*;
#(
  parameter int width_p       = 32,
  parameter int slice_width_p = 8,
  parameter int idx_p         = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               down_ready_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic [width_p-1:0] s_i,
  input  logic               c_i,
  output logic               v_o,
  output logic               ready_o,
  output logic [width_p-1:0] a_o,
  output logic [width_p-1:0] b_o,
  output logic [width_p-1:0] s_o,
  output logic               c_o
);

  localparam int lsb_lp   = idx_p * slice_width_p;
  localparam int sum_w_lp = slice_width_p + 1;

  bsg_adder_stage_e state, state_n;
  logic             adv;
  logic [sum_w_lp-1:0] slice_sum;
  logic [width_p-1:0]  s_n;

  assign v_o     = (state == eFull);
  assign adv     = v_o & down_ready_i;
  assign ready_o = ~v_o | adv;

  assign slice_sum = {1'b0, a_i[lsb_lp +: slice_width_p]}
                   + {1'b0, b_i[lsb_lp +: slice_width_p]}
                   + sum_w_lp'(c_i);

  // Upstream partial sums are zero at and above this slice, so OR-ing
  // the new slice in is the same as inserting it.
  assign s_n = s_i | (width_p'(slice_sum[slice_width_p-1:0]) << lsb_lp);

  // Occupancy register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= eEmpty;
    else         state <= state_n;
  end

  // Next occupancy: a load always fills (replacing data that leaves in
  // the same cycle); an advance with no load empties.
  always_comb begin
    state_n = state;
    if (load_i)   state_n = eFull;
    else if (adv) state_n = eEmpty;
  end

  // Data registers capture only on load and otherwise hold.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_o <= '0;
      b_o <= '0;
      s_o <= '0;
      c_o <= 1'b0;
    end else if (load_i) begin
      a_o <= a_i;
      b_o <= b_i;
      s_o <= s_n;
      c_o <= slice_sum[slice_width_p];
    end
  end

endmodule

// File: rtl/bsg_adder_pipelined.sv
// Pipelined ripple-carry add/subtract with valid/ready input and
// valid/yumi output handshakes. Latency is stages_p cycles.
// Optional output ovf_o (signed overflow) is built when the macro
// BSG_ADDER_PIPELINED_OVERFLOW_EN is defined.
module bsg_adder_pipelined
  import bsg_adder_pkg::*;
#(
  parameter int width_p  = 32,
  parameter int stages_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               c_i,
  input  logic               sub_i,
  output logic               v_o,
  output logic [width_p-1:0] s_o,
  output logic               c_o,
  input  logic               yumi_i
`ifdef BSG_ADDER_PIPELINED_OVERFLOW_EN
  ,output logic              ovf_o
`endif
);

  localparam int slice_width_lp = slice_width(width_p, stages_p);
  localparam int last_lp        = stages_p - 1;

  bsg_adder_op_e op;
  logic          invert;

  logic [stages_p-1:0] v, ready, load, down_ready, c_in, c_q;
  logic [width_p-1:0]  a_in [stages_p];
  logic [width_p-1:0]  b_in [stages_p];
  logic [width_p-1:0]  s_in [stages_p];
  logic [width_p-1:0]  a_q  [stages_p];
  logic [width_p-1:0]  b_q  [stages_p];
  logic [width_p-1:0]  s_q  [stages_p];

  assign op     = bsg_adder_op_e'(sub_i);
  assign invert = (op == eSub);

  for (genvar k = 0; k < stages_p; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtract is folded in at capture: invert B and the carry-in.
      assign load[k] = v_i & ready[0];
      assign a_in[k] = a_i;
      assign b_in[k] = b_i ^ {width_p{invert}};
      assign s_in[k] = '0;
      assign c_in[k] = c_i ^ invert;
    end else begin : g_body
      assign load[k] = v[k-1] & ready[k];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = c_q[k-1];
    end

    if (k == last_lp) begin : g_tail
      assign down_ready[k] = yumi_i;
    end else begin : g_mid
      assign down_ready[k] = ready[k+1];
    end

    bsg_adder_pipe_stage #(
      .width_p       (width_p),
      .slice_width_p (slice_width_lp),
      .idx_p         (k)
    ) u_stage (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .load_i       (load[k]),
      .down_ready_i (down_ready[k]),
      .a_i          (a_in[k]),
      .b_i          (b_in[k]),
      .s_i          (s_in[k]),
      .c_i          (c_in[k]),
      .v_o          (v[k]),
      .ready_o      (ready[k]),
      .a_o          (a_q[k]),
      .b_o          (b_q[k]),
      .s_o          (s_q[k]),
      .c_o          (c_q[k])
    );
  end

  assign ready_o = ready[0];
  assign v_o     = v[last_lp];
  assign s_o     = s_q[last_lp];
  assign c_o     = c_q[last_lp];

`ifdef BSG_ADDER_PIPELINED_OVERFLOW_EN
  // Carry into the MSB is recovered from the registered MSB operand and
  // sum bits, so the flag is a pure function of last-stage registers:
  // it clears on reset and holds while stalled.
  assign ovf_o = a_q[last_lp][width_p-1] ^ b_q[last_lp][width_p-1]
               ^ s_q[last_lp][width_p-1] ^ c_q[last_lp];
`endif

endmodule

// File: tb/tb_bsg_adder_pipelined.sv
// Self-checking bench for bsg_adder_pipelined (width 32, 4 slices).
module tb_bsg_adder_pipelined;

  localparam int W = 32;
  localparam int S = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         rst, v_i, ready, c_i, sub, v_o, c_o, yumi;
  logic [W-1:0] a, b, s;
  logic         ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   yumi_en, lat_chk, last_acc;

  bsg_adder_pipelined #(.width_p(W), .stages_p(S)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .v_i     (v_i),
    .ready_o (ready),
    .a_i     (a),
    .b_i     (b),
    .c_i     (c_i),
    .sub_i   (sub),
    .v_o     (v_o),
    .s_o     (s),
    .c_o     (c_o),
    .yumi_i  (yumi)
`ifdef BSG_ADDER_PIPELINED_OVERFLOW_EN
    ,.ovf_o  (ovf)
`endif
  );

`ifndef BSG_ADDER_PIPELINED_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  // Consumer must never take a result that is not offered.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(yumi && !v_o)) else begin
        errors++;
        $error("FAIL yumi_protocol obs=%b exp=0", yumi);
      end
    end
  end

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] pa, input logic [W-1:0] pb,
                                 input logic pc, input logic psub, input int acc);
    exp_t   e;
    longint ua, ub, sa, sb, r, sr, ci;
    ua = longint'(pa);
    ub = longint'(pb);
    sa = longint'($signed(pa));
    sb = longint'($signed(pb));
    ci = pc ? 64'sd1 : 64'sd0;
    if (!psub) begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      e.c = (r > 64'sd4294967295);
    end else begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      e.c = (r >= 0);
    end
    e.s   = r[W-1:0];
    e.ovf = (sr > SMAX) || (sr < SMIN);
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock: consume/score at the falling edge, advance at the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    yumi = yumi_en & v_o;
    #1;
    last_acc = v_i & ready;
    if (last_acc) q.push_back(model(a, b, c_i, sub, cyc));
    if (yumi) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(v_o), 64'd0);
      end else begin
        e = q.pop_front();
        chk("s_o", 64'(s), 64'(e.s));
        chk("c_o", 64'(c_o), 64'(e.c));
`ifdef BSG_ADDER_PIPELINED_OVERFLOW_EN
        chk("ovf_o", 64'(ovf), 64'(e.ovf));
`endif
        if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'(S));
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    yumi = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] pa, input logic [W-1:0] pb,
                      input logic pc, input logic psub);
    v_i = 1'b1; a = pa; b = pb; c_i = pc; sub = psub;
    for (int n = 0; n < 100; n++) begin
      step();
      if (last_acc) break;
    end
    chk("send_accepted", 64'(last_acc), 64'd1);
    v_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && q.size() > 0; n++) step();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] pa [6];
    logic [W-1:0] pb [6];
    int idx;

    rst = 1'b1; v_i = 1'b0; yumi = 1'b0; a = '0; b = '0; c_i = 1'b0; sub = 1'b0;
    yumi_en = 1'b1; lat_chk = 1'b1; last_acc = 1'b0;

    #12;
    chk("reset_v_o", 64'(v_o), 64'd0);
    chk("reset_s_o", 64'(s), 64'd0);
    chk("reset_c_o", 64'(c_o), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready", 64'(ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed corner cases.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
`ifdef BSG_ADDER_PIPELINED_OVERFLOW_EN
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
`endif
    drain();

    // Back-to-back random stream.
    for (int i = 0; i < 16; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    // Stall: consumer withholds yumi while six pairs are offered.
    yumi_en = 1'b0;
    lat_chk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    idx = 0;
    for (int n = 0; n < 10; n++) begin
      if (idx < 6) begin
        v_i = 1'b1; a = pa[idx]; b = pb[idx]; c_i = 1'b0; sub = idx[0];
      end else begin
        v_i = 1'b0;
      end
      step();
      if (last_acc) idx++;
    end
    chk("stall_accepted", 64'(idx), 64'd4);
    chk("stall_ready", 64'(ready), 64'd0);
    chk("stall_v_o", 64'(v_o), 64'd1);
    if (q.size() > 0) begin
      chk("stall_s_hold", 64'(s), 64'(q[0].s));
      chk("stall_c_hold", 64'(c_o), 64'(q[0].c));
    end
    yumi_en = 1'b1;
    for (int n = 0; n < 50 && idx < 6; n++) begin
      v_i = 1'b1; a = pa[idx]; b = pb[idx]; c_i = 1'b0; sub = idx[0];
      step();
      if (last_acc) idx++;
    end
    v_i = 1'b0;
    chk("stall_all_accepted", 64'(idx), 64'd6);
    drain();
    lat_chk = 1'b1;

    // Asynchronous reset with results in flight.
    yumi_en = 1'b0;
    send(32'd1, 32'd1, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0);
    send(32'd3, 32'd3, 1'b0, 1'b0);
    step();
    chk("pre_reset_v_o", 64'(v_o), 64'd1);
    chk("pre_reset_s_o", 64'(s), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_v_o", 64'(v_o), 64'd0);
    chk("async_reset_s_o", 64'(s), 64'd0);
    chk("async_reset_c_o", 64'(c_o), 64'd0);
    chk("async_reset_ovf", 64'(ovf), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    yumi_en = 1'b1;
    repeat (10) step();
    chk("no_stale_v_o", 64'(v_o), 64'd0);

    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
